spi_master_ctrl: RTL
====================

Name: spi_master_ctrl

Overview:
- Upstream stage of the SPI slave + RAM wrapper. Converts parallel command requests into single-wire serial frames on Mosi/ss_n, and captures read data returned on Miso.
- Runs on the same system clock as the slave: one serial bit per clk cycle, no separate SCK.
- A host issues one command per start pulse. The block reports completion, and for read-data commands it returns the byte.

Parameters:
- RD_GAP, 2, number of clk cycles after the last command bit before the first Miso bit is sampled (slave/RAM turnaround); legal range 1..15.
- DATA_W, 8, payload and read-data width; frame length is DATA_W+2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only when busy=0.
- cmd  input  2  00 write address, 01 write data, 10 read address, 11 read data.
- payload  input  DATA_W  address or write data; don't-care for cmd=11.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at frame end.
- rd_data  output  DATA_W  last byte captured by a cmd=11 frame; holds until the next cmd=11 completes.
- rd_valid  output  1  one-cycle pulse coincident with done for cmd=11 only.
- ss_n  output  1  slave select, active-low, registered.
- Mosi  output  1  serial data to slave, registered.
- Miso  input  1  serial data from slave.

Behaviour:
- One clock; all state updates on rising clk. Reset is synchronous and active-high.
- Reset values: ss_n=1, Mosi=0, busy=0, done=0, rd_valid=0, rd_data=0, state=IDLE, all counters 0.
- Reset mid-frame aborts the frame:
  - ss_n=1 after the reset edge.
  - No done or rd_valid pulse is issued.
  - rd_data is cleared.
- FSM states: IDLE, SEL, SHIFT, GAP, RECV, END.
- IDLE:
  - ss_n=1, Mosi=0, busy=0.
  - start=1 latches frame={cmd,payload} (DATA_W+2 bits) and moves to SEL.
- SEL (1 cycle): ss_n=0, Mosi=cmd[1] (select bit: 0 write, 1 read); busy=1.
- SHIFT (DATA_W+2 cycles):
  - ss_n=0; Mosi = frame bits MSB first, frame[DATA_W+1] down to frame[0].
  - After the last bit: go to GAP if cmd=11, else to END.
- GAP (RD_GAP cycles): ss_n=0, Mosi=0, Miso ignored.
- RECV (DATA_W cycles):
  - ss_n=0, Mosi=0.
  - Miso is sampled at the rising edge ending each RECV cycle and shifted in MSB first.
- END (1 cycle):
  - ss_n=1, Mosi=0, busy=1, done=1.
  - If cmd=11: rd_data is updated with the shift register and rd_valid=1 in this same cycle.
  - Then go to IDLE.
- Latency, with the start edge at cycle 0:
  - Write/read-address frame: ss_n low cycles 1..DATA_W+3, done at cycle DATA_W+4 (default: low 1..11, done at 12).
  - Read-data frame: done at DATA_W+4+RD_GAP+DATA_W (default 22).
- Frame spacing: start is ignored while busy=1, including the END cycle. The earliest next acceptance is the cycle after END, which guarantees ss_n is high for at least 2 cycles between frames.
- start held high continuously produces back-to-back frames separated by the END and IDLE cycles.
- cmd/payload changes after acceptance have no effect on the frame in flight.
- Counters are wide enough for max(DATA_W+2, RD_GAP) and do not wrap within a frame.

Test Plan:
- Write address: start with cmd=00, payload=0x2A.
  - ss_n low cycles 1..11.
  - Mosi = 0, then 0,0,0,0,1,0,1,0,1,0.
  - done at cycle 12; rd_valid=0.
- Write data: cmd=01, payload=0xFF.
  - Mosi = 0, then 0,1,1,1,1,1,1,1,1,1.
  - busy high cycles 1..12; done at 12.
- Read address then read data: cmd=10 payload=0x2A, then cmd=11; slave model drives 0xC3 on Miso MSB first in RECV cycles.
  - Second frame: select bit 1, then Mosi=1,1,0,...,0.
  - rd_data=0xC3, rd_valid and done at cycle 22 relative to the second start.
- Start while busy: pulse start at cycles 5 and 12 of a write frame.
  - Both pulses ignored; no second frame begins.
  - A start at cycle 13 is accepted and ss_n falls at cycle 14.
- Reset mid-frame: assert rst at cycle 6 of a cmd=11 frame.
  - Next edge: ss_n=1, busy=0, rd_data=0.
  - No done or rd_valid pulse.
  - A subsequent start runs a complete, correct frame.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: turns {cmd,payload} requests into ss_n/Mosi serial frames and captures read bytes from Miso.
module spi_master_ctrl #(
  parameter int RD_GAP = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] payload,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              ss_n,
  output logic              Mosi,
  input  logic              Miso
);
  localparam int MX = (DATA_W + 2 > RD_GAP) ? DATA_W + 2 : RD_GAP;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [2:0] {IDLE, SEL, SHIFT, GAP, RECV, END} state_t;
  state_t            state;
  logic [DATA_W+1:0] frame;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_nx;
  logic [CW-1:0]     cnt;
  logic              is_rd;
  assign sr_nx = {sr[DATA_W-2:0], Miso};
  // Outputs are registered, so each transition loads the values of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      frame    <= '0;
      sr       <= '0;
      cnt      <= '0;
      is_rd    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      ss_n     <= 1'b1;
      Mosi     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          frame <= {cmd, payload};
          is_rd <= &cmd;
          state <= SEL;
          ss_n  <= 1'b0;
          Mosi  <= cmd[1];
          busy  <= 1'b1;
        end
        SEL: begin
          state <= SHIFT;
          Mosi  <= frame[DATA_W+1];
          frame <= frame << 1;
          cnt   <= '0;
        end
        SHIFT: if (cnt == CW'(DATA_W + 1)) begin
          state <= is_rd ? GAP : END;
          ss_n  <= is_rd ? 1'b0 : 1'b1;
          done  <= ~is_rd;
          Mosi  <= 1'b0;
          cnt   <= '0;
        end else begin
          Mosi  <= frame[DATA_W+1];
          frame <= frame << 1;
          cnt   <= cnt + CW'(1);
        end
        GAP: begin
          state <= (cnt == CW'(RD_GAP - 1)) ? RECV : GAP;
          cnt   <= (cnt == CW'(RD_GAP - 1)) ? '0 : cnt + CW'(1);
        end
        RECV: begin
          sr <= sr_nx;
          if (cnt == CW'(DATA_W - 1)) begin
            state    <= END;
            ss_n     <= 1'b1;
            done     <= 1'b1;
            rd_valid <= 1'b1;
            rd_data  <= sr_nx;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        END: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
